// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: mode bit positions, mode encodings,
// FSM states and a width helper.
package spi_pkg;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Ceiling log2, minimum result 1 so counters always have at least one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between an SPI master and the responder.
interface spi_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport slave  (input  sclk, input  cs_n, input  mosi, output miso, output miso_oe);
    modport master (output sclk, output cs_n, output mosi, input  miso, input  miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizes an asynchronous input into clk and flags its rising/falling edges.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_c  = level_o & ~prev_q;
    assign fall_c  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI responder, all four CPOL/CPHA modes, pins oversampled in clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_if.slave        spi,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic sync_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .async_i(spi.sclk),
        .level_o(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst(rst), .async_i(spi.cs_n),
        .level_o(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    // cs_n level is not needed; only its edges drive the FSM.
    assign sync_unused = cs_lvl;

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_load_q, tx_load_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic              sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic [DATA_W-1:0] rx_next;

    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
    always_comb begin
        sclk_edge   = sclk_rise | sclk_fall;
        lead_edge   = sclk_edge & (sclk_lvl != mode_q[CPOL_BIT]);
        trail_edge  = sclk_edge & (sclk_lvl == mode_q[CPOL_BIT]);
        sample_edge = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
        shift_edge  = mode_q[CPHA_BIT] ? lead_edge  : trail_edge;
        rx_next     = {rx_sr_q[DATA_W-2:0], mosi_s};
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    cnt_d   = '0;
                    if (!mode[CPHA_BIT]) begin
                        tx_sr_d   = tx_data;
                        tx_load_d = 1'b1;
                    end else begin
                        tx_sr_d = '1;
                    end
                end
            end
            ACTIVE: begin
                // Deselect takes priority over any sclk edge in the same cycle.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                end else if (sample_edge) begin
                    rx_sr_d = rx_next;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (cnt_q == '0) begin
                        tx_sr_d   = tx_data;
                        tx_load_d = 1'b1;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d == ACTIVE);
        miso_oe_d = (state_d == ACTIVE);
        miso_d    = (state_d == ACTIVE) ? tx_sr_d[DATA_W-1] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            mode_q      <= MODE0;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign tx_load     = tx_load_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a master model drives frames, a monitor checks outputs.
`timescale 1ns/1ps
module tb_spi_slave;
    import spi_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned HALF   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;

    spi_slave_if spi ();

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi(spi.slave), .mode(mode),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rx_cnt = 0, load_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];
    logic [7:0] miso_got[$];
    logic [7:0] tx_q[$];
    logic [7:0] mosi_q[$];
    time        last_samp_t = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic half_per();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    // Master model: nbytes full bytes, then optionally abort_bits of a partial byte.
    task automatic spi_frame(input logic [1:0] m, input int nbytes, input int abort_bits, input bit toggle);
        logic [7:0] b;
        logic [7:0] rd;
        int nb;
        int nbits;
        mode = m;
        spi.sclk = m[1];
        half_per();
        half_per();
        spi.cs_n = 1'b0;
        nb = nbytes + ((abort_bits > 0) ? 1 : 0);
        for (int k = 0; k < nb; k++) begin
            nbits = (k == nbytes) ? abort_bits : 8;
            b = mosi_q.pop_front();
            rd = '0;
            if (k < nbytes) rx_exp.push_back(b);
            for (int i = 7; i > 7 - nbits; i--) begin
                if (!m[0]) begin
                    spi.mosi = b[i];
                    half_per();
                    rd = {rd[6:0], spi.miso};
                    spi.sclk = ~m[1];
                    if (i == 0) last_samp_t = $time;
                    half_per();
                    spi.sclk = m[1];
                end else begin
                    half_per();
                    spi.sclk = ~m[1];
                    spi.mosi = b[i];
                    half_per();
                    rd = {rd[6:0], spi.miso};
                    spi.sclk = m[1];
                    if (i == 0) last_samp_t = $time;
                end
                if (toggle) mode = ~m;
            end
            if (k < nbytes) miso_got.push_back(rd);
        end
        half_per();
        spi.cs_n = 1'b1;
        mode = m;
        half_per();
        half_per();
    endtask

    // User-side tx feeder and output monitor.
    initial begin
        tx_data = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            if (tx_load) begin
                load_cnt++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'hFF;
            if (rx_valid) begin
                rx_cnt++;
                if (rx_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %0h expected no rx_valid at %0t", rx_data, $time);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
                    check("rx_latency", 32'(($time - last_samp_t) / 10), 32'd3);
                end
            end
            if (frame_err) ferr_cnt++;
            if (rx_valid && tx_load) both_cnt++;
            while (miso_got.size() > 0) begin
                if (miso_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL miso_unexpected: got %0h expected nothing", miso_got.pop_front());
                end else begin
                    check("miso_byte", 32'(miso_got.pop_front()), 32'(miso_exp.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, ld0, fe0, n;
        logic [7:0] t, d;
        rst = 1'b1;
        mode = MODE0;
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        #23;
        check("rst_miso", 32'(spi.miso), 32'd1);
        check("rst_miso_oe", 32'(spi.miso_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({rx_valid, tx_load, frame_err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        half_per();

        // Mode 0 single byte
        rx0 = rx_cnt; ld0 = load_cnt; fe0 = ferr_cnt;
        mosi_q.push_back(8'hA5); tx_q.push_back(8'h3C); miso_exp.push_back(8'h3C);
        spi_frame(MODE0, 1, 0, 1'b0);
        check("m0_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("m0_load_count", 32'(load_cnt - ld0), 32'd2);
        check("m0_ferr", 32'(ferr_cnt - fe0), 32'd0);
        check("m0_miso_oe_off", 32'(spi.miso_oe), 32'd0);
        check("m0_miso_idle", 32'(spi.miso), 32'd1);

        // Mode 3 two-byte frame
        rx0 = rx_cnt; ld0 = load_cnt; fe0 = ferr_cnt;
        mosi_q.push_back(8'h12); mosi_q.push_back(8'h34);
        tx_q.push_back(8'hF0); tx_q.push_back(8'h0F);
        miso_exp.push_back(8'hF0); miso_exp.push_back(8'h0F);
        spi_frame(MODE3, 2, 0, 1'b0);
        check("m3_rx_count", 32'(rx_cnt - rx0), 32'd2);
        check("m3_load_count", 32'(load_cnt - ld0), 32'd2);
        check("m3_ferr", 32'(ferr_cnt - fe0), 32'd0);

        // Modes 1 and 2 single byte
        rx0 = rx_cnt;
        mosi_q.push_back(8'h81); tx_q.push_back(8'h81); miso_exp.push_back(8'h81);
        spi_frame(MODE1, 1, 0, 1'b0);
        mosi_q.push_back(8'h81); tx_q.push_back(8'h81); miso_exp.push_back(8'h81);
        spi_frame(MODE2, 1, 0, 1'b0);
        check("m12_rx_count", 32'(rx_cnt - rx0), 32'd2);

        // Abort after 5 bits in mode 0
        rx0 = rx_cnt; fe0 = ferr_cnt;
        mosi_q.push_back(8'hC7); tx_q.push_back(8'h55);
        spi_frame(MODE0, 0, 5, 1'b0);
        tx_q.delete();
        check("abort_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("abort_rx_hold", 32'(rx_data), 32'h81);
        check("abort_miso", 32'(spi.miso), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);

        // Reset mid-byte in mode 1
        tx_q.push_back(8'h99);
        mode = MODE1;
        spi.sclk = 1'b0;
        half_per();
        spi.cs_n = 1'b0;
        half_per();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_miso_oe", 32'(spi.miso_oe), 32'd1);
        for (int i = 0; i < 3; i++) begin
            half_per();
            spi.sclk = 1'b1;
            spi.mosi = 1'b1;
            half_per();
            spi.sclk = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check("mrst_miso", 32'(spi.miso), 32'd1);
        check("mrst_miso_oe", 32'(spi.miso_oe), 32'd0);
        check("mrst_rx_data", 32'(rx_data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_pulses", 32'({rx_valid, tx_load, frame_err}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        half_per();
        check("post_rst_idle", 32'(busy), 32'd0);
        spi.cs_n = 1'b1;
        tx_q.delete();
        half_per();
        rx0 = rx_cnt; fe0 = ferr_cnt;
        mosi_q.push_back(8'h5A); tx_q.push_back(8'hC3); miso_exp.push_back(8'hC3);
        spi_frame(MODE1, 1, 0, 1'b0);
        check("post_rst_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("post_rst_ferr", 32'(ferr_cnt - fe0), 32'd0);

        // Loopback in all modes with mode pin toggled mid-frame
        rx0 = rx_cnt; fe0 = ferr_cnt;
        for (int mm = 0; mm < 4; mm++) begin
            n = $urandom_range(1, 16);
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom());
                t = 8'($urandom());
                mosi_q.push_back(d);
                tx_q.push_back(t);
                miso_exp.push_back(t);
            end
            spi_frame(2'(mm), n, 0, 1'b1);
            tx_q.delete();
        end
        check("loop_ferr", 32'(ferr_cnt - fe0), 32'd0);

        half_per();
        check("rx_drained", 32'(rx_exp.size()), 32'd0);
        check("miso_drained", 32'(miso_exp.size()), 32'd0);
        check("rx_tx_same_cycle", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI responder (slave) for the FPGA control path. It is the target-side counterpart of the in-house SPI master.
- Oversamples sclk, cs_n and mosi in the clk domain and supports all four CPOL/CPHA modes.
- Receives a byte on mosi while shifting a byte out on miso. Supports back-to-back multi-byte frames while cs_n stays low.
- Byte handshakes to user logic are single-cycle pulses.

Parameters:
DATA_W, 8, bits per transfer word (MSB first)
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (min 2)

Ports:
clk  in  1  system clock; must be >= 8x sclk frequency
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock from master (async to clk)
cs_n  in  1  chip select, active low (async)
mosi  in  1  master-out data (async)
miso  out  1  slave-out data; 1 when deselected
miso_oe  out  1  output enable for pad tristate; 1 while selected
mode  in  2  {CPOL,CPHA}; sampled at cs_n falling edge only
tx_data  in  DATA_W  next byte to send; must be stable when tx_load pulses
tx_load  out  1  1-clk pulse: tx_data captured; user presents next byte before the next byte boundary
rx_data  out  DATA_W  last received byte; holds until next rx_valid
rx_valid  out  1  1-clk pulse: rx_data updated
frame_err  out  1  1-clk pulse: cs_n rose with partial byte
busy  out  1  1 while in ACTIVE

Behaviour:
- Reset (async, any time, including mid-frame) forces:
  - state IDLE
  - miso=1, miso_oe=0, rx_data=0
  - rx_valid/tx_load/frame_err/busy=0
  - bit_cnt=0, shift regs=0
- After reset, a frame is recognised only at a new cs_n falling edge.
- Synchronization and edge detection:
  - sclk, cs_n and mosi each pass SYNC_STAGES flops.
  - An edge is detected when the synchronized value differs from its one-cycle-delayed copy.
  - All actions occur on the clk edge following detection.
  - Latency from pin edge to output pulse is SYNC_STAGES+1 clk.
- Edge roles:
  - Leading edge = sclk leaving CPOL level; trailing edge = returning to CPOL.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
  - The CPOL/CPHA used are the values latched at cs_n fall.
- FSM IDLE -> ACTIVE on synchronized cs_n fall:
  - latch mode; bit_cnt=0; miso_oe=1; busy=1.
  - If CPHA=0: tx_sr<=tx_data, tx_load pulse (bit7 visible on miso before first leading edge).
  - If CPHA=1: tx_sr<=all ones.
- ACTIVE, sample edge:
  - rx_sr<={rx_sr[DATA_W-2:0],mosi_s}; bit_cnt++ (wraps mod DATA_W).
  - If bit_cnt was DATA_W-1: rx_data<={rx_sr[DATA_W-2:0],mosi_s}, rx_valid pulse.
- ACTIVE, shift edge:
  - If bit_cnt==0: tx_sr<=tx_data, tx_load pulse.
  - Otherwise: tx_sr<=tx_sr<<1.
  - A load at bit_cnt==0 also occurs on the final trailing edge of a CPHA=0 frame. It is harmless, and tx_load still pulses.
- miso = tx_sr[DATA_W-1] when ACTIVE, else 1.
- ACTIVE -> IDLE on synchronized cs_n rise:
  - miso_oe=0, busy=0.
  - If bit_cnt!=0: frame_err pulse; partial byte discarded (no rx_valid).
  - bit_cnt=0.
- Simultaneous events:
  - cs_n rise in the same cycle as an sclk edge: the cs_n rise wins and the sclk edge is ignored.
  - sclk edges while IDLE are ignored.
  - mode changes while ACTIVE are ignored.
- rx_valid and tx_load never assert in the same cycle within one edge. They may coincide only through cs_n fall with CPHA=0 (tx_load only).

Decomposition:
- Package spi_pkg holds:
  - mode bit indices (CPOL=1, CPHA=0) and the mode constants MODE0..MODE3
  - the state enum (IDLE, ACTIVE)
  - a clog2 helper for bit_cnt width
- One sub-module, spi_sync_edge (parameter SYNC_STAGES):
  - async input -> synchronized level, rise pulse, fall pulse
  - instantiated for sclk and cs_n; mosi uses the level output only.

Test Plan:
- Mode 0, clk=8x sclk, master sends 0xA5 and tx_data=0x3C → master reads 0x3C; rx_data=0xA5 with a single rx_valid pulse; tx_load exactly at cs_n fall and once after the last trailing edge; miso_oe low after cs_n rise.
- Mode 3 two-byte frame, master sends 0x12,0x34, tx_data 0xF0 then 0x0F (switched after the first tx_load) → two rx_valid pulses with 0x12 then 0x34; master reads 0xF0,0x0F; no frame_err.
- Mode 1 and mode 2 single byte 0x81 each way → correct bits in both directions; rx_valid occurs 3 clk after the 8th sample pin edge.
- Abort: cs_n rises after 5 sclk cycles in mode 0 → frame_err pulse, no rx_valid, rx_data holds its previous value, miso=1.
- rst asserted mid-byte in mode 1 → all outputs take reset values immediately. A new frame 0x5A after reset release is received correctly.
- Randomized loopback against the in-house SPI master model: all 4 modes, 1-16 bytes/frame, random data → rx/tx match scoreboard; mode toggled mid-frame has no effect.
